// File: rtl/sine_pkg.sv
// Shared definitions for the sine generator / decimator pair.
package sine_pkg;

    localparam int DEFAULT_WINDOW = 256;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

endpackage

// File: rtl/sine_dec_outreg.sv
// Output holding register for the decimator: keeps a completed window
// total until the consumer takes it, and flags totals that had to be dropped.
module sine_dec_outreg
    import sine_pkg::*;
#(
    parameter int SW = 9
) (
    input  logic          clk_100,
    input  logic          rst_n,
    input  logic          i_load,
    input  logic [SW-1:0] i_total,
    input  logic          i_ready,
    input  logic          i_ovr_clr,
    output logic [SW-1:0] o_sample,
    output logic          o_valid,
    output logic          o_overrun
);

    logic [SW-1:0] r_sample;
    logic          r_valid;
    logic          r_overrun;
    logic          w_handshake;
    logic          w_drop;

    assign w_handshake = r_valid & i_ready;
    // A total arriving while an unconsumed one is still held is lost.
    assign w_drop      = i_load & r_valid & ~i_ready;

    // Load a new total when the register is free or being emptied this cycle.
    always_ff @(posedge clk_100) begin
        if (!rst_n) begin
            r_sample <= '0;
            r_valid  <= 1'b0;
        end else if (i_load && (!r_valid || i_ready)) begin
            r_sample <= i_total;
            r_valid  <= 1'b1;
        end else if (w_handshake) begin
            r_valid  <= 1'b0;
        end
    end

    // Sticky overrun; a drop in the same cycle as a clear keeps it set.
    always_ff @(posedge clk_100) begin
        if (!rst_n) begin
            r_overrun <= 1'b0;
        end else if (w_drop) begin
            r_overrun <= 1'b1;
        end else if (i_ovr_clr) begin
            r_overrun <= 1'b0;
        end
    end

    assign o_sample  = r_sample;
    assign o_valid   = r_valid;
    assign o_overrun = r_overrun;

endmodule

// File: rtl/sine_decimator.sv
// Counts ones in fixed windows of a 1-bit sine bitstream and hands each
// window total to a valid/ready consumer.
// Optional build macro SINE_DECIMATOR_SYNC_EN: bit_in (and en, so that the
// window framing stays aligned with the bits) pass through a 2-flop
// synchroniser, delaying every sample by two cycles.
//
// state | meaning
// IDLE  | counters held at zero, waiting for en
// RUN   | counting a window; total emitted every WINDOW cycles
module sine_decimator
    import sine_pkg::*;
#(
    parameter int WINDOW = DEFAULT_WINDOW,
    parameter int SW     = $clog2(WINDOW) + 1
) (
    input  logic          clk_100,
    input  logic          rst_n,
    input  logic          bit_in,
    input  logic          en,
    input  logic          sample_ready,
    input  logic          ovr_clr,
    output logic [SW-1:0] sample,
    output logic          sample_valid,
    output logic          overrun
);

    localparam int            CW   = $clog2(WINDOW);
    localparam logic [CW-1:0] LAST = CW'(WINDOW - 1);

    logic          w_bit;
    logic          w_en;
    state_t        r_state;
    state_t        w_state_nxt;
    logic [CW-1:0] r_win_cnt;
    logic [SW-1:0] r_ones_acc;
    logic          w_run;
    logic          w_last;
    logic [SW-1:0] w_total;

`ifdef SINE_DECIMATOR_SYNC_EN
    logic [1:0] r_bit_sync;
    logic [1:0] r_en_sync;

    // Two-flop synchroniser; en rides along so windows frame the same bits.
    always_ff @(posedge clk_100) begin
        if (!rst_n) begin
            r_bit_sync <= 2'b00;
            r_en_sync  <= 2'b00;
        end else begin
            r_bit_sync <= {r_bit_sync[0], bit_in};
            r_en_sync  <= {r_en_sync[0], en};
        end
    end

    assign w_bit = r_bit_sync[1];
    assign w_en  = r_en_sync[1];
`else
    assign w_bit = bit_in;
    assign w_en  = en;
`endif

    // FSM state register.
    always_ff @(posedge clk_100) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM next-state logic.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (w_en)  w_state_nxt = RUN;
            RUN:     if (!w_en) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    assign w_run   = (r_state == RUN) && w_en;
    assign w_last  = w_run && (r_win_cnt == LAST);
    assign w_total = r_ones_acc + {{(SW-1){1'b0}}, w_bit};

    // Window counter and ones accumulator; a dropped en discards the partial window.
    always_ff @(posedge clk_100) begin
        if (!rst_n || !w_run) begin
            r_win_cnt  <= '0;
            r_ones_acc <= '0;
        end else if (w_last) begin
            r_win_cnt  <= '0;
            r_ones_acc <= '0;
        end else begin
            r_win_cnt  <= r_win_cnt + CW'(1);
            r_ones_acc <= w_total;
        end
    end

    sine_dec_outreg #(
        .SW (SW)
    ) u_outreg (
        .clk_100   (clk_100),
        .rst_n     (rst_n),
        .i_load    (w_last),
        .i_total   (w_total),
        .i_ready   (sample_ready),
        .i_ovr_clr (ovr_clr),
        .o_sample  (sample),
        .o_valid   (sample_valid),
        .o_overrun (overrun)
    );

endmodule

// File: tb/tb_sine_decimator.sv
// Directed bench for sine_decimator with WINDOW=8.
module tb_sine_decimator;

    localparam int WINDOW = 8;
    localparam int SW     = 4;
`ifdef SINE_DECIMATOR_SYNC_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 0;
`endif
    localparam int FIRST = 9 + LAT;

    logic          clk_100 = 1'b0;
    logic          rst_n;
    logic          bit_in;
    logic          en;
    logic          sample_ready;
    logic          ovr_clr;
    logic [SW-1:0] sample;
    logic          sample_valid;
    logic          overrun;

    int checks   = 0;
    int failures = 0;
    int tab[8]   = '{128, 218, 255, 218, 128, 37, 0, 37};

    always #5 clk_100 = ~clk_100;

    sine_decimator #(
        .WINDOW (WINDOW),
        .SW     (SW)
    ) dut (
        .clk_100      (clk_100),
        .rst_n        (rst_n),
        .bit_in       (bit_in),
        .en           (en),
        .sample_ready (sample_ready),
        .ovr_clr      (ovr_clr),
        .sample       (sample),
        .sample_valid (sample_valid),
        .overrun      (overrun)
    );

    task automatic tick;
        @(posedge clk_100);
        #1;
    endtask

    task automatic do_reset;
        rst_n = 1'b0; en = 1'b0; bit_in = 1'b0; sample_ready = 1'b0; ovr_clr = 1'b0;
        tick;
        tick;
        rst_n = 1'b1;
    endtask

    task automatic test_reset;
        rst_n = 1'b0; en = 1'b1; bit_in = 1'b1; sample_ready = 1'b1; ovr_clr = 1'b0;
        tick;
        checks++; if (sample !== 4'd0) begin failures++; $display("FAIL reset_sample: got %0d expected 0", sample); end
        checks++; if (sample_valid !== 1'b0) begin failures++; $display("FAIL reset_valid: got %0b expected 0", sample_valid); end
        checks++; if (overrun !== 1'b0) begin failures++; $display("FAIL reset_overrun: got %0b expected 0", overrun); end
    endtask

    // Modes: 0 all ones, 1 alternating 1/0, 2 all zeros; ready always high.
    task automatic test_streams;
        logic       exp_v;
        logic [3:0] exp_val;
        for (int m = 0; m < 3; m++) begin
            do_reset;
            sample_ready = 1'b1;
            en = 1'b1;
            exp_val = (m == 0) ? 4'd8 : (m == 1) ? 4'd4 : 4'd0;
            for (int n = 1; n <= FIRST + 16; n++) begin
                bit_in = (m == 0) ? 1'b1 : (m == 1) ? n[0] : 1'b0;
                tick;
                exp_v = (n >= FIRST) && (((n - FIRST) % 8) == 0);
                checks++;
                if (sample_valid !== exp_v) begin
                    failures++;
                    $display("FAIL stream%0d_valid n=%0d: got %0b expected %0b", m, n, sample_valid, exp_v);
                end
                if (exp_v) begin
                    checks++;
                    if (sample !== exp_val) begin
                        failures++;
                        $display("FAIL stream%0d_sample n=%0d: got %0d expected %0d", m, n, sample, exp_val);
                    end
                end
            end
        end
    endtask

    task automatic test_overrun;
        do_reset;
        en = 1'b1; bit_in = 1'b1; sample_ready = 1'b0;
        for (int n = 1; n <= 20; n++) begin
            tick;
            if (n == FIRST) begin
                checks++; if (sample_valid !== 1'b1 || sample !== 4'd8) begin failures++; $display("FAIL ovr_first: got valid=%0b sample=%0d expected valid=1 sample=8", sample_valid, sample); end
            end
            if (n == 16 + LAT) begin
                checks++; if (overrun !== 1'b0) begin failures++; $display("FAIL ovr_early: got %0b expected 0", overrun); end
            end
            if (n == 17 + LAT) begin
                checks++; if (overrun !== 1'b1) begin failures++; $display("FAIL ovr_set: got %0b expected 1", overrun); end
                checks++; if (sample !== 4'd8 || sample_valid !== 1'b1) begin failures++; $display("FAIL ovr_hold: got valid=%0b sample=%0d expected valid=1 sample=8", sample_valid, sample); end
            end
        end
        checks++; if (overrun !== 1'b1) begin failures++; $display("FAIL ovr_sticky: got %0b expected 1", overrun); end
        ovr_clr = 1'b1;
        tick;
        ovr_clr = 1'b0;
        checks++; if (overrun !== 1'b0) begin failures++; $display("FAIL ovr_clear: got %0b expected 0", overrun); end
        for (int n = 22; n <= 24 + LAT; n++) tick;
        // Clear pulse coincides with the next dropped total.
        ovr_clr = 1'b1;
        tick;
        ovr_clr = 1'b0;
        checks++; if (overrun !== 1'b1) begin failures++; $display("FAIL ovr_set_wins: got %0b expected 1", overrun); end
        checks++; if (sample !== 4'd8) begin failures++; $display("FAIL ovr_sample_kept: got %0d expected 8", sample); end
    endtask

    task automatic test_coincide;
        do_reset;
        en = 1'b1; sample_ready = 1'b0;
        for (int n = 1; n <= 17 + LAT; n++) begin
            bit_in = (n <= 9);
            sample_ready = (n == 17 + LAT);
            tick;
            if (n == 12 || n == 16 + LAT) begin
                checks++; if (sample_valid !== 1'b1 || sample !== 4'd8) begin failures++; $display("FAIL coin_stable n=%0d: got valid=%0b sample=%0d expected valid=1 sample=8", n, sample_valid, sample); end
            end
        end
        sample_ready = 1'b0;
        checks++; if (sample !== 4'd0 || sample_valid !== 1'b1) begin failures++; $display("FAIL coin_load: got valid=%0b sample=%0d expected valid=1 sample=0", sample_valid, sample); end
        checks++; if (overrun !== 1'b0) begin failures++; $display("FAIL coin_overrun: got %0b expected 0", overrun); end
        sample_ready = 1'b1;
        tick;
        sample_ready = 1'b0;
        checks++; if (sample_valid !== 1'b0) begin failures++; $display("FAIL coin_consumed: got %0b expected 0", sample_valid); end
    endtask

    task automatic test_en_drop;
        do_reset;
        en = 1'b1; bit_in = 1'b1; sample_ready = 1'b0;
        for (int n = 1; n <= 14; n++) tick;
        // Dropped while the second window sits at count 5.
        en = 1'b0;
        for (int n = 15; n <= 24; n++) tick;
        checks++; if (sample !== 4'd8 || sample_valid !== 1'b1) begin failures++; $display("FAIL drop_hold: got valid=%0b sample=%0d expected valid=1 sample=8", sample_valid, sample); end
        checks++; if (overrun !== 1'b0) begin failures++; $display("FAIL drop_overrun: got %0b expected 0", overrun); end
        sample_ready = 1'b1;
        tick;
        sample_ready = 1'b0;
        checks++; if (sample_valid !== 1'b0) begin failures++; $display("FAIL drop_consumed: got %0b expected 0", sample_valid); end
        en = 1'b1;
        for (int m = 1; m <= FIRST; m++) begin
            bit_in = m[0];
            tick;
            checks++;
            if (sample_valid !== (m == FIRST)) begin
                failures++;
                $display("FAIL drop_restart_valid m=%0d: got %0b expected %0b", m, sample_valid, (m == FIRST));
            end
        end
        checks++; if (sample !== 4'd4) begin failures++; $display("FAIL drop_restart_sample: got %0d expected 4", sample); end
    endtask

    task automatic test_reset_mid;
        do_reset;
        en = 1'b1; bit_in = 1'b1; sample_ready = 1'b0;
        for (int n = 1; n <= 19 + LAT; n++) tick;
        checks++; if (overrun !== 1'b1 || sample_valid !== 1'b1) begin failures++; $display("FAIL rmid_pre: got valid=%0b overrun=%0b expected 1 1", sample_valid, overrun); end
        rst_n = 1'b0;
        tick;
        checks++; if (sample !== 4'd0 || sample_valid !== 1'b0 || overrun !== 1'b0) begin failures++; $display("FAIL rmid_clear: got sample=%0d valid=%0b overrun=%0b expected 0 0 0", sample, sample_valid, overrun); end
        rst_n = 1'b1;
        for (int m = 1; m <= FIRST; m++) begin
            tick;
            checks++;
            if (sample_valid !== (m == FIRST)) begin
                failures++;
                $display("FAIL rmid_restart_valid m=%0d: got %0b expected %0b", m, sample_valid, (m == FIRST));
            end
        end
        checks++; if (sample !== 4'd8) begin failures++; $display("FAIL rmid_restart_sample: got %0d expected 8", sample); end
    endtask

    // First-order delta-sigma sine bitstream; each total is checked against
    // the bits the bench itself drove in that window.
    task automatic test_sine_stream;
        int   acc;
        int   nsamp;
        int   k;
        int   exp_sum;
        logic bits[1:80];
        do_reset;
        sample_ready = 1'b1;
        en = 1'b1;
        acc = 0;
        nsamp = 0;
        for (int n = 1; n <= 80; n++) begin
            acc += tab[(n / 4) % 8];
            if (acc >= 256) begin
                bit_in = 1'b1;
                acc -= 256;
            end else begin
                bit_in = 1'b0;
            end
            bits[n] = bit_in;
            tick;
            if (sample_valid === 1'b1) begin
                nsamp++;
                checks++;
                if (n < FIRST || ((n - FIRST) % 8) != 0) begin
                    failures++;
                    $display("FAIL sine_timing: got valid at n=%0d expected n=%0d+8k", n, FIRST);
                end else begin
                    k = (n - 1 - LAT) / 8;
                    exp_sum = 0;
                    for (int j = 8 * k - 6; j <= 8 * k + 1; j++) exp_sum += int'(bits[j]);
                    if (int'(sample) != exp_sum) begin
                        failures++;
                        $display("FAIL sine_sample n=%0d: got %0d expected %0d", n, sample, exp_sum);
                    end
                end
                checks++;
                if (int'(sample) > WINDOW) begin
                    failures++;
                    $display("FAIL sine_range n=%0d: got %0d expected <= %0d", n, sample, WINDOW);
                end
            end
        end
        checks++; if (nsamp != 9) begin failures++; $display("FAIL sine_count: got %0d expected 9", nsamp); end
    endtask

    initial begin
        test_reset;
        test_streams;
        test_overrun;
        test_coincide;
        test_en_drop;
        test_reset_mid;
        test_sine_stream;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
